// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: detector outtype codes, forwarding
// select values and the stall-controller state encoding.
package hazard_pkg;

  localparam logic [3:0] OT_NONE   = 4'd0;
  localparam logic [3:0] OT_ALU_RS = 4'd1;
  localparam logic [3:0] OT_ALU_RT = 4'd2;
  localparam logic [3:0] OT_LD_RS  = 4'd3;
  localparam logic [3:0] OT_LD_RT  = 4'd4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } hz_state_t;

  // A report is meaningful only with conf set and a code in 1..4.
  function automatic logic code_valid(input logic conf, input logic [3:0] ot);
    return conf && (ot >= OT_ALU_RS) && (ot <= OT_LD_RT);
  endfunction

endpackage

// File: rtl/fwd_sel_enc.sv
// Maps the distance-one and distance-two conflict reports onto next rs/rt
// forwarding selects; distance-one wins per operand.
module fwd_sel_enc
  import hazard_pkg::*;
(
  input  logic       conf1,
  input  logic [3:0] outtype1,
  input  logic       conf2,
  input  logic [3:0] outtype2,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic [1:0] d2_a,
  output logic [1:0] d2_b
);

  logic v1, v2;

  always_comb begin
    v1    = code_valid(conf1, outtype1);
    v2    = code_valid(conf2, outtype2);
    // Distance-two load codes also forward from MEM/WB: the load has data by then.
    d2_a  = (v2 && (outtype2 == OT_ALU_RS || outtype2 == OT_LD_RS)) ? FWD_WB : FWD_RF;
    d2_b  = (v2 && (outtype2 == OT_ALU_RT || outtype2 == OT_LD_RT)) ? FWD_WB : FWD_RF;
    sel_a = (v1 && outtype1 == OT_ALU_RS) ? FWD_MEM : d2_a;
    sel_b = (v1 && outtype1 == OT_ALU_RT) ? FWD_MEM : d2_b;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control: load-use stall/bubble generation and registered E-stage
// forwarding selects. Optional statistics counters under HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1
`ifdef HAZARD_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conf1,
  input  logic [3:0]       outtype1,
  input  logic             conf2,
  input  logic [3:0]       outtype2,
  input  logic             pipe_hold,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel
`ifdef HAZARD_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] fwd_cnt
`endif
);

  // With a single bubble the load is still in WB-reach; longer stalls let it retire.
  localparam logic [1:0] LAT_SEL = (LOAD_STALL_CYCLES == 1) ? FWD_WB : FWD_RF;

  hz_state_t  state, state_nx;
  logic [1:0] scnt, scnt_nx;
  logic       lat_rt, lat_rt_nx;
  logic       ld_hit, stall, exit_edge;
  logic [1:0] enc_a, enc_b, d2_a, d2_b;
  logic [1:0] a_nx, b_nx;

  fwd_sel_enc u_enc (
    .conf1    (conf1),
    .outtype1 (outtype1),
    .conf2    (conf2),
    .outtype2 (outtype2),
    .sel_a    (enc_a),
    .sel_b    (enc_b),
    .d2_a     (d2_a),
    .d2_b     (d2_b)
  );

  always_comb begin
    state_nx   = state;
    scnt_nx    = scnt;
    lat_rt_nx  = lat_rt;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_flush = 1'b0;
    stall      = 1'b0;
    exit_edge  = 1'b0;
    ld_hit     = code_valid(conf1, outtype1) &&
                 (outtype1 == OT_LD_RS || outtype1 == OT_LD_RT);

    if (pipe_hold) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state == LSTALL) begin
      // Detector reports are ignored here: the bubble in E yields spurious codes.
      stall   = 1'b1;
      scnt_nx = scnt - 2'd1;
      if (scnt == 2'd1) begin
        state_nx  = RUN;
        exit_edge = 1'b1;
      end
    end else if (ld_hit) begin
      stall     = 1'b1;
      lat_rt_nx = (outtype1 == OT_LD_RT);
      if (LOAD_STALL_CYCLES == 1) begin
        exit_edge = 1'b1;
      end else begin
        state_nx = LSTALL;
        scnt_nx  = 2'(LOAD_STALL_CYCLES - 1);
      end
    end

    if (stall || rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    a_nx = enc_a;
    b_nx = enc_b;
    if (exit_edge) begin
      a_nx = lat_rt_nx ? d2_a : LAT_SEL;
      b_nx = lat_rt_nx ? LAT_SEL : d2_b;
    end else if (stall) begin
      a_nx = FWD_RF;
      b_nx = FWD_RF;
    end
  end

  // ---- register stage: FSM and forwarding selects ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      scnt      <= 2'd0;
      lat_rt    <= 1'b0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (!pipe_hold) begin
      state     <= state_nx;
      scnt      <= scnt_nx;
      lat_rt    <= lat_rt_nx;
      fwd_a_sel <= a_nx;
      fwd_b_sel <= b_nx;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (idex_flush)
        stall_cnt <= sat_inc(stall_cnt);
      if (!pipe_hold && (a_nx != FWD_RF || b_nx != FWD_RF))
        fwd_cnt <= sat_inc(fwd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_STALL_CYCLES 1..3) share stimulus
// and are compared against a per-instance behavioural model.
module tb_hazard_ctrl;

  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pipe_hold = 1'b0;
  logic       conf1 = 1'b0, conf2 = 1'b0;
  logic [3:0] outtype1 = 4'd0, outtype2 = 4'd0;
  logic [2:0] pcw, ifw, flw;
  logic [1:0] fa [3];
  logic [1:0] fb [3];
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] sc [3];
  logic [CW-1:0] fc [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(
      .LOAD_STALL_CYCLES(g + 1)
`ifdef HAZARD_STATS_EN
      , .CNT_W(CW)
`endif
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .conf1      (conf1),
      .outtype1   (outtype1),
      .conf2      (conf2),
      .outtype2   (outtype2),
      .pipe_hold  (pipe_hold),
      .pc_write   (pcw[g]),
      .ifid_write (ifw[g]),
      .idex_flush (flw[g]),
      .fwd_a_sel  (fa[g]),
      .fwd_b_sel  (fb[g])
`ifdef HAZARD_STATS_EN
      , .stall_cnt(sc[g])
      , .fwd_cnt  (fc[g])
`endif
    );
  end

  int checks = 0;
  int failures = 0;

  // Behavioural model: remaining bubbles, latched operand, selects, counters.
  int rem [3];
  bit mlat [3];
  int ma [3];
  int mb [3];
  int msc [3];
  int mfc [3];
  bit minit = 1'b0;

  logic [1:0] obs_fa [3];
  logic [1:0] obs_fb [3];
  logic       obs_pc [3];
  logic       obs_fl [3];

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lsc=%0d t=%0t got=%0h want=%0h", nm, inst + 1, $time, act, exp);
    end
  endtask

  function automatic bit vld(input bit c, input bit [3:0] o);
    return c && o >= 1 && o <= 4;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic step(input bit r, input bit h, input bit c1, input bit [3:0] o1,
                      input bit c2, input bit [3:0] o2);
    bit ld, d1a, d1b, d2a, d2b, flush, ex;
    int ep, ef, na, nb, lsel;
    @(negedge clk);
    rst = r; pipe_hold = h; conf1 = c1; outtype1 = o1; conf2 = c2; outtype2 = o2;
    #1;
    ld  = vld(c1, o1) && (o1 == 3 || o1 == 4);
    d1a = vld(c1, o1) && o1 == 1;
    d1b = vld(c1, o1) && o1 == 2;
    d2a = vld(c2, o2) && (o2 == 1 || o2 == 3);
    d2b = vld(c2, o2) && (o2 == 2 || o2 == 4);
    for (int i = 0; i < 3; i++) begin
      if (r)                      begin ep = 0; ef = 1; end
      else if (h)                 begin ep = 0; ef = 0; end
      else if (rem[i] > 0 || ld)  begin ep = 0; ef = 1; end
      else                        begin ep = 1; ef = 0; end
      chk("pc_write", i, 32'(pcw[i]), ep);
      chk("ifid_write", i, 32'(ifw[i]), ep);
      chk("idex_flush", i, 32'(flw[i]), ef);
      if (minit) begin
        chk("fwd_a_sel", i, 32'(fa[i]), ma[i]);
        chk("fwd_b_sel", i, 32'(fb[i]), mb[i]);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", i, 32'(sc[i]), msc[i]);
        chk("fwd_cnt", i, 32'(fc[i]), mfc[i]);
`endif
      end
      obs_pc[i] = pcw[i]; obs_fl[i] = flw[i]; obs_fa[i] = fa[i]; obs_fb[i] = fb[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        rem[i] = 0; ma[i] = 0; mb[i] = 0; msc[i] = 0; mfc[i] = 0;
      end else if (!h) begin
        flush = (rem[i] > 0) || ld;
        ex = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          ex = (rem[i] == 0);
        end else if (ld) begin
          mlat[i] = (o1 == 4);
          rem[i] = i;
          ex = (i == 0);
        end
        if (ex) begin
          lsel = (i == 0) ? 2 : 0;
          na = mlat[i] ? (d2a ? 2 : 0) : lsel;
          nb = mlat[i] ? lsel : (d2b ? 2 : 0);
        end else if (flush) begin
          na = 0; nb = 0;
        end else begin
          na = d1a ? 1 : (d2a ? 2 : 0);
          nb = d1b ? 1 : (d2b ? 2 : 0);
        end
        if (flush) msc[i] = sat(msc[i]);
        if (na != 0 || nb != 0) mfc[i] = sat(mfc[i]);
        ma[i] = na; mb[i] = nb;
      end
    end
    if (r) minit = 1'b1;
  endtask

  typedef struct {
    bit       c1;
    bit [3:0] o1;
    bit       c2;
    bit [3:0] o2;
    bit       pc;
    bit       fl;
    bit [1:0] a;
    bit [1:0] b;
  } vec_t;

  vec_t tbl [12];
  int   fl3, fl2;

  initial begin
    // Expected values are for the LOAD_STALL_CYCLES=1 instance, observed this cycle.
    tbl[0]  = '{1, 4'd1, 0, 4'd0, 1, 0, 2'b00, 2'b00};
    tbl[1]  = '{0, 4'd0, 0, 4'd0, 1, 0, 2'b01, 2'b00};
    tbl[2]  = '{1, 4'd4, 0, 4'd0, 0, 1, 2'b00, 2'b00};
    tbl[3]  = '{0, 4'd0, 1, 4'd4, 1, 0, 2'b00, 2'b10};
    tbl[4]  = '{1, 4'd2, 1, 4'd2, 1, 0, 2'b00, 2'b10};
    tbl[5]  = '{1, 4'd7, 0, 4'd0, 1, 0, 2'b00, 2'b01};
    tbl[6]  = '{0, 4'd0, 1, 4'd3, 1, 0, 2'b00, 2'b00};
    tbl[7]  = '{0, 4'd0, 0, 4'd0, 1, 0, 2'b10, 2'b00};
    tbl[8]  = '{0, 4'd3, 0, 4'd0, 1, 0, 2'b00, 2'b00};
    tbl[9]  = '{1, 4'd3, 1, 4'd2, 0, 1, 2'b00, 2'b00};
    tbl[10] = '{0, 4'd0, 0, 4'd0, 1, 0, 2'b10, 2'b10};
    tbl[11] = '{0, 4'd0, 1, 4'd0, 1, 0, 2'b00, 2'b00};

    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      step(0, 0, tbl[k].c1, tbl[k].o1, tbl[k].c2, tbl[k].o2);
      chk($sformatf("tbl%0d_pc", k), 0, 32'(obs_pc[0]), 32'(tbl[k].pc));
      chk($sformatf("tbl%0d_flush", k), 0, 32'(obs_fl[0]), 32'(tbl[k].fl));
      chk($sformatf("tbl%0d_a", k), 0, 32'(obs_fa[0]), 32'(tbl[k].a));
      chk($sformatf("tbl%0d_b", k), 0, 32'(obs_fb[0]), 32'(tbl[k].b));
    end

    // Three-bubble load-use with garbage reports during the stall.
    step(1, 0, 0, 0, 0, 0);
    fl3 = 0; fl2 = 0;
    step(0, 0, 1, 4'd3, 0, 0); fl3 += obs_fl[2]; fl2 += obs_fl[1];
    step(0, 0, 1, 4'd4, 0, 0); fl3 += obs_fl[2]; fl2 += obs_fl[1];
    step(0, 0, 1, 4'd1, 0, 0); fl3 += obs_fl[2]; fl2 += obs_fl[1];
    step(0, 0, 0, 0, 0, 0);    fl3 += obs_fl[2]; fl2 += obs_fl[1];
    chk("lsc3_flush_cycles", 2, fl3, 3);
    chk("lsc2_flush_cycles", 1, fl2, 2);
    step(0, 0, 0, 0, 0, 0);
    chk("lsc3_exit_a", 2, 32'(obs_fa[2]), 0);

    // Load code held off by pipe_hold, then acted on.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 4'd4, 0, 0);
      chk("hold_pc", 0, 32'(obs_pc[0]), 0);
      chk("hold_flush", 0, 32'(obs_fl[0]), 0);
    end
    step(0, 0, 1, 4'd4, 0, 0);
    chk("hold_release_flush", 2, 32'(obs_fl[2]), 1);

    // Reset in the middle of a two-bubble stall.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4'd4, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_abort_pc", 1, 32'(obs_pc[1]), 1);
    chk("rst_abort_b", 1, 32'(obs_fb[1]), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_abort_b_later", 1, 32'(obs_fb[1]), 0);

`ifdef HAZARD_STATS_EN
    // Continuous load codes keep every instance stalling until the counter saturates.
    for (int k = 0; k < CMAX + 40; k++) step(0, 0, 1, 4'd3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) chk("stall_cnt_sat", i, 32'(sc[i]), CMAX);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stall_cnt_clear", 1, 32'(sc[1]), 0);
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
